// File: rtl/lamp_monitor.sv
// lamp_monitor: watches a two-lamp traffic signal and its two-digit 7-segment
// countdown and flags illegal segment codes, bad countdown or phase order,
// and illegal lamp combinations.
//
// Optional feature macro: MON_SEG_FILTER_EN. When defined, a tuple must be
// stable for 2 consecutive clocks before it is acted on, which gives a
// latency of 3 cycles. When undefined, every tuple is acted on directly with
// a latency of 1 cycle.
//
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   LED_RED    red lamp under observation
//   LED_GREEN  green lamp under observation
//   SS1/SS2    tens/units digit segments {g,f,e,d,c,b,a}, active-high
//   digit_bin  decoded count 0..99 (holds its value on illegal codes)
//   digit_vld  both segment codes legal
//   phase      00 WAIT, 01 RED, 10 GREEN, 11 FAULT
//   seg_err    sticky illegal segment code
//   seq_err    sticky countdown or phase-order violation
//   lamp_err   sticky illegal lamp combination
//   phase_cnt  completed phase changes, wraps at 255
module lamp_monitor #(
    parameter int unsigned RED_TIME   = 15,
    parameter int unsigned GREEN_TIME = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       LED_RED,
    input  logic       LED_GREEN,
    input  logic [6:0] SS1,
    input  logic [6:0] SS2,
    output logic [6:0] digit_bin,
    output logic       digit_vld,
    output logic [1:0] phase,
    output logic       seg_err,
    output logic       seq_err,
    output logic       lamp_err,
    output logic [7:0] phase_cnt
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 7;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TUP_W = 2 + 2 * SEG_W;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_RED   = 2'b01,
        ST_GREEN = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    // Segment code to {legal, value}.
    function automatic logic [4:0] seg_dec(input logic [SEG_W-1:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = {1'b1, 4'd0};
            7'h06:   r = {1'b1, 4'd1};
            7'h5B:   r = {1'b1, 4'd2};
            7'h4F:   r = {1'b1, 4'd3};
            7'h66:   r = {1'b1, 4'd4};
            7'h6D:   r = {1'b1, 4'd5};
            7'h7D:   r = {1'b1, 4'd6};
            7'h07:   r = {1'b1, 4'd7};
            7'h7F:   r = {1'b1, 4'd8};
            7'h6F:   r = {1'b1, 4'd9};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [DIG_W-1:0]   digit_bin_q, digit_bin_d;
    logic               digit_vld_q, digit_vld_d;
    logic               seg_err_q, seg_err_d;
    logic               seq_err_q, seq_err_d;
    logic               lamp_err_q, lamp_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIG_W-1:0]   ref_q, ref_d;

    logic [TUP_W-1:0]   tup_raw_c;
    logic [TUP_W-1:0]   tup_c;
    logic               act_c;

    assign tup_raw_c = {LED_RED, LED_GREEN, SS1, SS2};

`ifdef MON_SEG_FILTER_EN
    // Two-deep history; act only once both stages hold the same tuple.
    logic [TUP_W-1:0] flt1_q, flt2_q;
    logic             fv1_q, fv2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flt1_q <= '0;
            flt2_q <= '0;
            fv1_q  <= 1'b0;
            fv2_q  <= 1'b0;
        end else begin
            flt1_q <= tup_raw_c;
            flt2_q <= flt1_q;
            fv1_q  <= 1'b1;
            fv2_q  <= fv1_q;
        end
    end

    assign act_c = fv1_q & fv2_q & (flt1_q == flt2_q);
    assign tup_c = flt2_q;
`else
    assign act_c = 1'b1;
    assign tup_c = tup_raw_c;
`endif

    // Tuple fields and decode.
    logic             led_r_c, led_g_c, one_led_c, legal_c, any_err_c, own_led_c;
    logic [4:0]       d1_c, d2_c;
    logic [DIG_W-1:0] val_c, flip_tgt_c;

    assign led_r_c    = tup_c[TUP_W-1];
    assign led_g_c    = tup_c[TUP_W-2];
    assign d1_c       = seg_dec(tup_c[2*SEG_W-1:SEG_W]);
    assign d2_c       = seg_dec(tup_c[SEG_W-1:0]);
    assign legal_c    = d1_c[4] & d2_c[4];
    assign val_c      = DIG_W'(d1_c[3:0]) * DIG_W'(10) + DIG_W'(d2_c[3:0]);
    assign one_led_c  = led_r_c ^ led_g_c;
    assign any_err_c  = seg_err_q | seq_err_q | lamp_err_q;
    assign own_led_c  = (state_q == ST_RED) ? led_r_c : led_g_c;
    assign flip_tgt_c = (state_q == ST_RED) ? DIG_W'(GREEN_TIME) : DIG_W'(RED_TIME);

    // Judge the accepted tuple; sequence checks stop once any flag is set.
    logic start_c, flip_c, ref_upd_c, seg_bad_c, seq_bad_c, lamp_bad_c;

    always_comb begin : judge
        start_c    = 1'b0;
        flip_c     = 1'b0;
        ref_upd_c  = 1'b0;
        seg_bad_c  = 1'b0;
        seq_bad_c  = 1'b0;
        lamp_bad_c = 1'b0;
        if (act_c) begin
            seg_bad_c  = !legal_c;
            lamp_bad_c = (led_r_c & led_g_c) |
                         (!led_r_c & !led_g_c & (state_q != ST_WAIT));
            if (legal_c && one_led_c && !any_err_c) begin
                case (state_q)
                    ST_WAIT: begin
                        start_c   = 1'b1;
                        ref_upd_c = 1'b1;
                    end
                    ST_RED, ST_GREEN: begin
                        if (own_led_c) begin
                            if (val_c != ref_q) begin
                                ref_upd_c = 1'b1;
                                seq_bad_c = (val_c != DIG_W'(ref_q - DIG_W'(1)));
                            end
                        end else begin
                            // Lamp flip: judged on its own, even if the value also moved.
                            ref_upd_c = 1'b1;
                            if ((ref_q == '0) && (val_c == flip_tgt_c)) begin
                                flip_c = 1'b1;
                            end else begin
                                seq_bad_c = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any raised flag forces FAULT, which only reset leaves.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_FAULT: state_d = ST_FAULT;
            default: begin
                if (any_err_c) begin
                    state_d = ST_FAULT;
                end else if (start_c) begin
                    state_d = led_r_c ? ST_RED : ST_GREEN;
                end else if (flip_c) begin
                    state_d = (state_q == ST_RED) ? ST_GREEN : ST_RED;
                end
            end
        endcase
    end

    // FSM outputs.
    always_comb begin : outputs
        phase     = state_q;
        digit_bin = digit_bin_q;
        digit_vld = digit_vld_q;
        seg_err   = seg_err_q;
        seq_err   = seq_err_q;
        lamp_err  = lamp_err_q;
        phase_cnt = cnt_q;
    end

    // Datapath next values.
    always_comb begin : datapath
        digit_bin_d = digit_bin_q;
        digit_vld_d = digit_vld_q;
        seg_err_d   = seg_err_q | seg_bad_c;
        seq_err_d   = seq_err_q | seq_bad_c;
        lamp_err_d  = lamp_err_q | lamp_bad_c;
        cnt_d       = flip_c ? CNT_W'(cnt_q + CNT_W'(1)) : cnt_q;
        ref_d       = ref_upd_c ? val_c : ref_q;
        if (act_c) begin
            digit_vld_d = legal_c;
            if (legal_c) begin
                digit_bin_d = val_c;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            digit_bin_q <= '0;
            digit_vld_q <= 1'b0;
            seg_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            lamp_err_q  <= 1'b0;
            cnt_q       <= '0;
            ref_q       <= '0;
        end else begin
            digit_bin_q <= digit_bin_d;
            digit_vld_q <= digit_vld_d;
            seg_err_q   <= seg_err_d;
            seq_err_q   <= seq_err_d;
            lamp_err_q  <= lamp_err_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
        end
    end

endmodule

// File: tb/tb_lamp_monitor.sv
// Directed self-checking bench for lamp_monitor (default parameters).
module tb_lamp_monitor;

`ifdef MON_SEG_FILTER_EN
    localparam int LAT  = 3;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       LED_RED, LED_GREEN;
    logic [6:0] SS1, SS2;
    logic [6:0] digit_bin;
    logic       digit_vld;
    logic [1:0] phase;
    logic       seg_err, seq_err, lamp_err;
    logic [7:0] phase_cnt;

    int checks = 0;
    int errors = 0;

    lamp_monitor dut (
        .clk       (clk),
        .rstn      (rstn),
        .LED_RED   (LED_RED),
        .LED_GREEN (LED_GREEN),
        .SS1       (SS1),
        .SS2       (SS2),
        .digit_bin (digit_bin),
        .digit_vld (digit_vld),
        .phase     (phase),
        .seg_err   (seg_err),
        .seq_err   (seq_err),
        .lamp_err  (lamp_err),
        .phase_cnt (phase_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int bin, input int vld, input int ph,
                             input int se, input int qe, input int le, input int cnt);
        check({tag, ".digit_bin"}, 32'(digit_bin), 32'(bin));
        check({tag, ".digit_vld"}, 32'(digit_vld), 32'(vld));
        check({tag, ".phase"},     32'(phase),     32'(ph));
        check({tag, ".seg_err"},   32'(seg_err),   32'(se));
        check({tag, ".seq_err"},   32'(seq_err),   32'(qe));
        check({tag, ".lamp_err"},  32'(lamp_err),  32'(le));
        check({tag, ".phase_cnt"}, 32'(phase_cnt), 32'(cnt));
    endtask

    // Drive a tuple and sample just after it has been acted on.
    task automatic apply(input logic r, input logic g, input int v);
        @(negedge clk);
        LED_RED   = r;
        LED_GREEN = g;
        SS1       = seg(v / 10);
        SS2       = seg(v % 10);
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    // 10 ns active-low reset pulse with lamps off and a legal 00 display.
    task automatic rst_pulse(input string tag);
        @(negedge clk);
        LED_RED   = 1'b0;
        LED_GREEN = 1'b0;
        SS1       = seg(0);
        SS2       = seg(0);
        rstn      = 1'b0;
        #1;
        check_all(tag, 0, 0, 0, 0, 0, 0, 0);
        #9;
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        LED_RED   = 1'b0;
        LED_GREEN = 1'b0;
        SS1       = seg(0);
        SS2       = seg(0);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        apply(1'b0, 1'b0, 0);
        check_all("wait_off", 0, 1, 0, 0, 0, 0, 0);

        // Red countdown 15..0.
        apply(1'b1, 1'b0, 15);
        check_all("red_entry", 15, 1, 1, 0, 0, 0, 0);
        for (int v = 14; v >= 0; v--) begin
            apply(1'b1, 1'b0, v);
            check_all("red_down", v, 1, 1, 0, 0, 0, 0);
        end

        // Flip to green, hold, count down, flip back to red.
        apply(1'b0, 1'b1, 10);
        check_all("to_green", 10, 1, 2, 0, 0, 0, 1);
        apply(1'b0, 1'b1, 10);
        check_all("green_hold", 10, 1, 2, 0, 0, 0, 1);
        for (int v = 9; v >= 0; v--) begin
            apply(1'b0, 1'b1, v);
            check_all("green_down", v, 1, 2, 0, 0, 0, 1);
        end
        apply(1'b1, 1'b0, 15);
        check_all("to_red", 15, 1, 1, 0, 0, 0, 2);

        // Red 07 jumps to 05.
        for (int v = 14; v >= 7; v--) apply(1'b1, 1'b0, v);
        check_all("red_07", 7, 1, 1, 0, 0, 0, 2);
        apply(1'b1, 1'b0, 5);
        check_all("jump", 5, 1, 1, 0, 1, 0, 2);
        @(posedge clk);
        #1;
        check_all("jump_fault", 5, 1, 3, 0, 1, 0, 2);
        apply(1'b0, 1'b1, 10);
        check_all("fault_frozen", 10, 1, 3, 0, 1, 0, 2);
        repeat (5) @(posedge clk);
        #1;
        check_all("fault_sticky", 10, 1, 3, 0, 1, 0, 2);

        // Reset out of FAULT, then reset again mid-count.
        rst_pulse("rst_fault");
        apply(1'b1, 1'b0, 12);
        check_all("reenter_red", 12, 1, 1, 0, 0, 0, 0);
        apply(1'b1, 1'b0, 11);
        check_all("red_11", 11, 1, 1, 0, 0, 0, 0);
        rst_pulse("rst_midcount");
        apply(1'b0, 1'b1, 7);
        check_all("reenter_green", 7, 1, 2, 0, 0, 0, 0);
        apply(1'b0, 1'b1, 6);
        check_all("green_6", 6, 1, 2, 0, 0, 0, 0);

        // One-cycle blank units digit.
        @(negedge clk);
        SS2 = 7'h00;
        @(posedge clk);
        #1;
        check("glitch.seg_err", 32'(seg_err), FILT ? 32'd0 : 32'd1);
        check("glitch.digit_vld", 32'(digit_vld), FILT ? 32'd1 : 32'd0);
        check("glitch.digit_bin", 32'(digit_bin), 32'd6);
        @(negedge clk);
        SS2 = seg(6);
        repeat (LAT + 1) @(posedge clk);
        #1;
        check_all("glitch_after", 6, 1, FILT ? 2 : 3, FILT ? 0 : 1, 0, 0, 0);

        // Both lamps: off in WAIT ignored, both on is an error.
        rst_pulse("rst_lamp");
        apply(1'b0, 1'b0, 33);
        check_all("wait_both_off", 33, 1, 0, 0, 0, 0, 0);
        apply(1'b0, 1'b1, 20);
        check_all("green_20", 20, 1, 2, 0, 0, 0, 0);
        apply(1'b1, 1'b1, 20);
        check_all("both_on", 20, 1, 2, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        check_all("both_on_fault", 20, 1, 3, 0, 0, 1, 0);

        // Flip to red showing the wrong start value.
        rst_pulse("rst_badflip");
        apply(1'b0, 1'b1, 1);
        apply(1'b0, 1'b1, 0);
        check_all("green_0", 0, 1, 2, 0, 0, 0, 0);
        apply(1'b1, 1'b0, 14);
        check_all("bad_flip_val", 14, 1, 2, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        check("bad_flip_val.fault", 32'(phase), 32'd3);

        // Both lamps off after WAIT.
        rst_pulse("rst_off");
        apply(1'b1, 1'b0, 3);
        apply(1'b0, 1'b0, 3);
        check_all("both_off", 3, 1, 1, 0, 0, 1, 0);

        // Flip before the count reached zero.
        rst_pulse("rst_early");
        apply(1'b1, 1'b0, 2);
        apply(1'b0, 1'b1, 10);
        check_all("early_flip", 10, 1, 1, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
